exec_stage_mc: RTL and testbench
================================

// Module: exec_stage_mc
// PURPOSE
//  Next-generation execute stage: forwarding muxes, single-cycle ALU and an iterative
//  CORDIC trig unit (sin/cos), with registered EXE/MEM outputs. Sits between the
//  DECO/EXE and EXE/MEM pipeline points. Multi-cycle trig ops stall decode via busy.
// PARAMETERS
//  N     32  datapath width (bits), two's complement
//  FRAC  16  fractional bits of the trig fixed-point format (Q(N-FRAC).FRAC)
//  ITER  16  CORDIC iterations = trig latency in cycles (1..N-1)
// PORTS
//  clk           in   1    clock, all state on rising edge
//  rst           in   1    synchronous reset, active-high
//  flush         in   1    squash in-flight op (branch taken)
//  in_valid      in   1    decode presents an op this cycle
//  trig_op       in   1    1 = CORDIC op (angle = selected src2), 0 = ALU op
//  alu_src       in   1    1 = src2 is imm, 0 = forwarded RD2
//  alu_ctrl      in   4    ALU opcode (see BEHAVIOUR)
//  fwd_src1/2    in   2    00 RD1/RD2, 01 from WB, 1x from MEM
//  fwd_ax/ay     in   2    same encoding for R0/R1
//  rd1,rd2,imm   in   N    decode operands
//  r0,r1         in   N    decode vector pair
//  fwd_wb,fwd_mem in  N    forwarded results
//  busy          out  1    trig op in progress; decode must hold
//  out_valid     out  1    EXE/MEM outputs hold a new result
//  alu_result    out  N    ALU result (trig op: 0)
//  ax,ay         out  N    forwarded R0/R1 (trig op: cos, sin)
//  wd            out  N    forwarded RD2 (store data)
//  flag_z/n/v/c  out  1    ALU flags (trig op: all 0)
// BEHAVIOUR
//  - Reset: state IDLE; busy, out_valid, all data/flags = 0. Reset mid-trig aborts, no output.
//  - Accept: in_valid & ~busy & ~flush at edge k. Operands captured after forwarding mux at k.
//  - ALU op: results registered at edge k; out_valid=1 in cycle k+1 only.
//  - alu_ctrl: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA (shift by src2[log2N-1:0]),
//    8 MOV (src2); others -> result 0. v,c only for ADD/SUB (c = carry / no-borrow), else 0.
//    z = (result==0), n = result[N-1].
//  - Trig op FSM: IDLE -accept&trig-> RUN (cnt=0, x=CORDIC_K, y=0, z=angle);
//    RUN: one rotation per edge, cnt++; at cnt==ITER-1 edge -> IDLE, ax=x, ay=y, out_valid=1
//    next cycle. busy=1 whenever state==RUN. Total latency ITER cycles.
//  - out_valid=0 while busy (bubble to MEM). New op may be accepted in the out_valid cycle.
//  - Angle domain [-pi/2, +pi/2] in Q format; outside -> results unspecified, no error.
//  - Rotation: d = sign(z); x'=x - d*(y>>>i); y'=y + d*(x>>>i); z'=z - d*ATAN_LUT[i]; arithmetic shifts.
//  - flush: IDLE/RUN -> IDLE, out_valid=0 next cycle; flush beats in_valid same cycle.
//  - in_valid while busy: ignored (decode holds it).
// CONFIGURATION
//  EXEC_STAGE_TRIG_EN defined: CORDIC unit present as above.
//  Not defined: no CORDIC logic; trig_op treated as MOV with ax/ay = forwarded r0/r1,
//  single-cycle; busy tied 0.
// STRUCTURE
//  stages_definition_pkg: alu_op_e, fwd_sel_e, exe_state_e, CORDIC_K, ATAN_LUT[0:N-1]
//  (atan(2^-i) in Q format, FRAC-parametrised function).
//  Sub-module cordic_engine (FSM + x/y/z regs + counter); ALU and muxes inline.
// TESTING (N=32, FRAC=16, ITER=16)
//  1 fwd_src1=1x fwd_mem=7, rd1=1, alu_src=1 imm=5, ADD -> alu_result=12, out_valid 1 cyc later.
//  2 ADD 0x7FFFFFFF+1 -> 0x80000000, v=1 n=1 z=0 c=0; SUB 5-5 -> 0, z=1 c=1.
//  3 trig angle=0 -> busy 16 cycles, then ax=0x00010000+-4, ay=0+-4, flags 0.
//  4 trig angle=0x0001921F (pi/2) -> ax=0+-4, ay=0x00010000+-4; back-to-back ALU op
//    accepted in out_valid cycle.
//  5 flush at RUN cycle 5 -> busy=0 next cycle, no out_valid; rst at cycle 8 of a
//    trig op -> all outputs 0 next cycle.
//  6 build without EXEC_STAGE_TRIG_EN: trig_op, r0=3 r1=4 -> ax=3 ay=4 after 1 cycle, busy=0.

Source files
------------

// File: rtl/stages_definition_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, forwarding selects,
// trig FSM states and the CORDIC constants in the trig fixed-point format.
// Two helper functions rescale the Q2.30 constant tables to any FRAC < 30.
package stages_definition_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_MOV = 4'd8
    } alu_op_e;

    // Bit 1 set means MEM, whatever bit 0 is.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } exe_state_e;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;

    // Product of cos(atan(2^-i)) over all iterations, in Q2.30.
    localparam logic [63:0] K_Q30 = 64'd652032874;

    // atan(2^-i) in Q2.30. From i=10 on, atan(2^-i) equals 2^-i to well
    // below one LSB of any format this is rescaled to.
    function automatic logic [63:0] atan_q30(input int i);
        case (i)
            0:       return 64'h3243F6A8;
            1:       return 64'h1DAC6705;
            2:       return 64'h0FADBAFC;
            3:       return 64'h07F56EA6;
            4:       return 64'h03FEAB76;
            5:       return 64'h01FFD55B;
            6:       return 64'h00FFFAAA;
            7:       return 64'h007FFF55;
            8:       return 64'h003FFFEA;
            9:       return 64'h001FFFFD;
            default: return (i > 30) ? 64'd0 : (64'd1 << (30 - i));
        endcase
    endfunction

    // Round-to-nearest rescale from Q2.30 to Q.frac (frac < 30).
    function automatic logic [63:0] to_frac(input logic [63:0] q30, input int frac);
        return (q30 + (64'd1 << (29 - frac))) >> (30 - frac);
    endfunction

    function automatic logic [63:0] atan_q(input int i, input int frac);
        return to_frac(atan_q30(i), frac);
    endfunction

    function automatic logic [DATA_W-1:0][DATA_W-1:0] atan_table(input int frac);
        logic [DATA_W-1:0][DATA_W-1:0] t;
        for (int i = 0; i < DATA_W; i++) begin
            t[i] = DATA_W'(atan_q(i, frac));
        end
        return t;
    endfunction

    localparam logic [DATA_W-1:0]             CORDIC_K = DATA_W'(to_frac(K_Q30, FRAC_W));
    localparam logic [DATA_W-1:0][DATA_W-1:0] ATAN_LUT = atan_table(FRAC_W);

endpackage

// File: rtl/exec_stage_mc_cordic.sv
// cordic_engine: iterative rotation-mode CORDIC, one micro-rotation per clock.
// Ports: clk, rst (sync, active-high), flush (abort), start (load angle and
// begin), angle (Q.FRAC), busy (RUN state), done (final rotation this edge),
// cos_val/sin_val (rotated x/y; valid when done is high).
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | waiting for start; x/y/z hold last values
// ST_RUN  | rotating, cnt = index of rotation applied next edge
module cordic_engine
    import stages_definition_pkg::*;
#(
    parameter int N    = 32,
    parameter int FRAC = 16,
    parameter int ITER = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                start,
    input  logic [N-1:0]        angle,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] cos_val,
    output logic signed [N-1:0] sin_val
);
    localparam int CW = $clog2(N);
    localparam logic signed [N-1:0] K_INIT = N'(to_frac(K_Q30, FRAC));

    exe_state_e          state;
    logic [CW-1:0]       cnt;
    logic signed [N-1:0] x, y, z;
    logic signed [N-1:0] x_sh, y_sh, atn, z_nxt;
    logic                d_neg;

    assign d_neg = z[N-1];
    assign x_sh  = x >>> cnt;
    assign y_sh  = y >>> cnt;
    assign atn   = N'(atan_q(int'(cnt), FRAC));

    // Rotate toward z = 0; a non-negative residual rotates counter-clockwise.
    assign cos_val = d_neg ? (x + y_sh) : (x - y_sh);
    assign sin_val = d_neg ? (y - x_sh) : (y + x_sh);
    assign z_nxt   = d_neg ? (z + atn)  : (z - atn);

    assign busy = (state == ST_RUN);
    assign done = (state == ST_RUN) && (cnt == CW'(ITER - 1)) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        x     <= K_INIT;
                        y     <= '0;
                        z     <= angle;
                    end
                end
                ST_RUN: begin
                    x   <= cos_val;
                    y   <= sin_val;
                    z   <= z_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/exec_stage_mc.sv
// exec_stage_mc: execute stage with operand forwarding, single-cycle ALU and
// an optional iterative CORDIC sin/cos unit; all EXE/MEM outputs registered.
// Inputs: clk, rst (sync, active-high), flush, in_valid, trig_op, alu_src,
// alu_ctrl, fwd_src1/2, fwd_ax/ay, rd1, rd2, imm, r0, r1, fwd_wb, fwd_mem.
// Outputs: busy, out_valid, alu_result, ax, ay, wd, flag_z/n/v/c.
// Build option EXEC_STAGE_TRIG_EN: when defined, trig_op runs the CORDIC unit
// (ITER cycles, busy held meanwhile). When undefined, trig_op is a
// single-cycle MOV with ax/ay carrying forwarded r0/r1 and busy tied low.
module exec_stage_mc
    import stages_definition_pkg::*;
#(
    parameter int N    = 32,
    parameter int FRAC = 16,
    parameter int ITER = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic         trig_op,
    input  logic         alu_src,
    input  logic [3:0]   alu_ctrl,
    input  logic [1:0]   fwd_src1,
    input  logic [1:0]   fwd_src2,
    input  logic [1:0]   fwd_ax,
    input  logic [1:0]   fwd_ay,
    input  logic [N-1:0] rd1,
    input  logic [N-1:0] rd2,
    input  logic [N-1:0] imm,
    input  logic [N-1:0] r0,
    input  logic [N-1:0] r1,
    input  logic [N-1:0] fwd_wb,
    input  logic [N-1:0] fwd_mem,
    output logic         busy,
    output logic         out_valid,
    output logic [N-1:0] alu_result,
    output logic [N-1:0] ax,
    output logic [N-1:0] ay,
    output logic [N-1:0] wd,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_v,
    output logic         flag_c
);
    localparam int SW = $clog2(N);

    function automatic logic [N-1:0] fwd_mux(input logic [1:0] sel, input logic [N-1:0] reg_v,
                                             input logic [N-1:0] wb_v, input logic [N-1:0] mem_v);
        if (sel[1])      return mem_v;
        else if (sel[0]) return wb_v;
        else             return reg_v;
    endfunction

    logic [N-1:0] src1, src2, rd2_fwd, ax_fwd, ay_fwd;
    logic [N:0]   sum, diff;
    logic [N-1:0] alu_res;
    logic         alu_v, alu_c;
    logic [3:0]   op_code;
    logic         accept, trig_start, trig_done;
    logic [N-1:0] cos_q, sin_q;

    assign src1    = fwd_mux(fwd_src1, rd1, fwd_wb, fwd_mem);
    assign rd2_fwd = fwd_mux(fwd_src2, rd2, fwd_wb, fwd_mem);
    assign src2    = alu_src ? imm : rd2_fwd;
    assign ax_fwd  = fwd_mux(fwd_ax, r0, fwd_wb, fwd_mem);
    assign ay_fwd  = fwd_mux(fwd_ay, r1, fwd_wb, fwd_mem);

    // flush outranks in_valid; busy makes decode hold its op.
    assign accept = in_valid && !busy && !flush;

`ifdef EXEC_STAGE_TRIG_EN
    assign op_code    = alu_ctrl;
    assign trig_start = accept && trig_op;

    cordic_engine #(.N(N), .FRAC(FRAC), .ITER(ITER)) u_cordic (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .start   (trig_start),
        .angle   (src2),
        .busy    (busy),
        .done    (trig_done),
        .cos_val (cos_q),
        .sin_val (sin_q)
    );
`else
    assign op_code    = trig_op ? ALU_MOV : alu_ctrl;
    assign trig_start = 1'b0;
    assign trig_done  = 1'b0;
    assign busy       = 1'b0;
    assign cos_q      = '0;
    assign sin_q      = '0;
`endif

    // Carry out of SUB is the no-borrow bit: a + ~b + 1.
    assign sum  = {1'b0, src1} + {1'b0, src2};
    assign diff = {1'b0, src1} + {1'b0, ~src2} + (N+1)'(1);

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (op_code)
            ALU_ADD: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = (src1[N-1] == src2[N-1]) && (sum[N-1] != src1[N-1]);
            end
            ALU_SUB: begin
                alu_res = diff[N-1:0];
                alu_c   = diff[N];
                alu_v   = (src1[N-1] != src2[N-1]) && (diff[N-1] != src1[N-1]);
            end
            ALU_AND: alu_res = src1 & src2;
            ALU_OR:  alu_res = src1 | src2;
            ALU_XOR: alu_res = src1 ^ src2;
            ALU_SLL: alu_res = src1 << src2[SW-1:0];
            ALU_SRL: alu_res = src1 >> src2[SW-1:0];
            ALU_SRA: alu_res = $signed(src1) >>> src2[SW-1:0];
            ALU_MOV: alu_res = src2;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            alu_result <= '0;
            ax         <= '0;
            ay         <= '0;
            wd         <= '0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
            flag_v     <= 1'b0;
            flag_c     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                wd <= rd2_fwd;
                if (trig_start) begin
                    // Result arrives later from the CORDIC; ALU side reads as zero.
                    alu_result <= '0;
                    flag_z     <= 1'b0;
                    flag_n     <= 1'b0;
                    flag_v     <= 1'b0;
                    flag_c     <= 1'b0;
                end else begin
                    alu_result <= alu_res;
                    flag_z     <= (alu_res == '0);
                    flag_n     <= alu_res[N-1];
                    flag_v     <= alu_v;
                    flag_c     <= alu_c;
                    ax         <= ax_fwd;
                    ay         <= ay_fwd;
                    out_valid  <= 1'b1;
                end
            end
            if (trig_done) begin
                ax        <= cos_q;
                ay        <= sin_q;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed bench for exec_stage_mc. Trig sequences are used when the bench is
// built with EXEC_STAGE_TRIG_EN, the single-cycle trig fallback otherwise.
module tb_exec_stage_mc;
    import stages_definition_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        trig_op;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic [1:0]  fwd_src1, fwd_src2, fwd_ax, fwd_ay;
    logic [31:0] rd1, rd2, imm, r0, r1, fwd_wb, fwd_mem;
    logic        busy, out_valid;
    logic [31:0] alu_result, ax, ay, wd;
    logic        flag_z, flag_n, flag_v, flag_c;

    int vec_cnt = 0;
    int err_cnt = 0;

    exec_stage_mc #(.N(32), .FRAC(16), .ITER(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .trig_op    (trig_op),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .fwd_src1   (fwd_src1),
        .fwd_src2   (fwd_src2),
        .fwd_ax     (fwd_ax),
        .fwd_ay     (fwd_ay),
        .rd1        (rd1),
        .rd2        (rd2),
        .imm        (imm),
        .r0         (r0),
        .r1         (r1),
        .fwd_wb     (fwd_wb),
        .fwd_mem    (fwd_mem),
        .busy       (busy),
        .out_valid  (out_valid),
        .alu_result (alu_result),
        .ax         (ax),
        .ay         (ay),
        .wd         (wd),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_v     (flag_v),
        .flag_c     (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                             input int tol = 0);
        longint d;
        d = longint'($signed(obs - exp));
        if (d < 0) d = -d;
        vec_cnt++;
        if (d > longint'(tol)) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; trig_op = 0; alu_src = 0; alu_ctrl = 4'd0;
        fwd_src1 = 2'b00; fwd_src2 = 2'b00; fwd_ax = 2'b00; fwd_ay = 2'b00;
        rd1 = 0; rd2 = 0; imm = 0; r0 = 0; r1 = 0; fwd_wb = 0; fwd_mem = 0;
    endtask

    // ALU op src1=a (rd1), src2=b (imm), flags packed as {z,n,v,c}.
    task automatic alu_vec(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input logic [3:0] exp_flags);
        idle_inputs();
        rd1 = a; imm = b; alu_src = 1; alu_ctrl = ctrl; in_valid = 1;
        step();
        in_valid = 0;
        check_vec({tag, "_res"}, alu_result, exp_res);
        check_vec({tag, "_flags"}, 32'({flag_z, flag_n, flag_v, flag_c}), 32'(exp_flags));
        check_vec({tag, "_ov"}, 32'(out_valid), 32'd1);
    endtask

    task automatic start_trig(input logic [31:0] angle);
        idle_inputs();
        trig_op = 1; alu_src = 1; imm = angle; in_valid = 1;
        step();
        in_valid = 0; trig_op = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ov_seen;
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        check_vec("rst_ov", 32'(out_valid), 32'd0);
        check_vec("rst_busy", 32'(busy), 32'd0);
        check_vec("rst_res", alu_result, 32'd0);
        check_vec("rst_ax", ax, 32'd0);
        check_vec("rst_flags", 32'({flag_z, flag_n, flag_v, flag_c}), 32'd0);

        // Forward MEM into src1, immediate into src2.
        idle_inputs();
        fwd_src1 = 2'b10; fwd_mem = 7; rd1 = 1; alu_src = 1; imm = 5; alu_ctrl = 4'd0; in_valid = 1;
        step();
        in_valid = 0;
        check_vec("fwd_mem_add_res", alu_result, 32'd12);
        check_vec("fwd_mem_add_ov", 32'(out_valid), 32'd1);
        step();
        check_vec("ov_one_cycle", 32'(out_valid), 32'd0);

        // WB into src1, MEM (sel 11) into src2/wd, ax from MEM, ay from WB.
        idle_inputs();
        fwd_src1 = 2'b01; fwd_wb = 100; rd1 = 55; fwd_src2 = 2'b11; fwd_mem = 20; rd2 = 999;
        fwd_ax = 2'b10; fwd_ay = 2'b01; r0 = 1; r1 = 2; alu_ctrl = 4'd1; in_valid = 1;
        step();
        in_valid = 0;
        check_vec("fwd_wb_sub_res", alu_result, 32'd80);
        check_vec("fwd_wd", wd, 32'd20);
        check_vec("fwd_ax_mem", ax, 32'd20);
        check_vec("fwd_ay_wb", ay, 32'd100);

        alu_vec("add_ovf",  4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110);
        alu_vec("sub_zero", 4'd1, 32'd5,        32'd5,        32'h00000000, 4'b1001);
        alu_vec("sub_neg",  4'd1, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b0100);
        alu_vec("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1001);
        alu_vec("sub_ovf",  4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011);
        alu_vec("and",      4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100);
        alu_vec("or",       4'd3, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000);
        alu_vec("xor",      4'd4, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b1000);
        alu_vec("sll_mask", 4'd5, 32'h00000001, 32'h00000024, 32'h00000010, 4'b0000);
        alu_vec("srl",      4'd6, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000);
        alu_vec("sra",      4'd7, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b0100);
        alu_vec("mov",      4'd8, 32'h00000005, 32'h12345678, 32'h12345678, 4'b0000);
        alu_vec("undef_op", 4'd9, 32'h00000005, 32'h00000006, 32'h00000000, 4'b1000);

        // flush wins over in_valid.
        idle_inputs();
        rd1 = 1; imm = 1; alu_src = 1; in_valid = 1; flush = 1;
        step();
        in_valid = 0; flush = 0;
        check_vec("flush_beats_valid", 32'(out_valid), 32'd0);

`ifdef EXEC_STAGE_TRIG_EN
        // angle 0: cos=1.0, sin=0 after 16 busy cycles.
        start_trig(32'h0);
        check_vec("trig0_ov_busy", 32'(out_valid), 32'd0);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
        check_vec("trig0_busy_cycles", 32'(n), 32'd16);
        check_vec("trig0_ov", 32'(out_valid), 32'd1);
        check_vec("trig0_cos", ax, 32'h00010000, 4);
        check_vec("trig0_sin", ay, 32'h00000000, 4);
        check_vec("trig0_flags", 32'({flag_z, flag_n, flag_v, flag_c}), 32'd0);
        check_vec("trig0_res", alu_result, 32'd0);

        // angle pi/2, then an ALU op issued in the out_valid cycle.
        start_trig(32'h0001921F);
        n = 0;
        while (!out_valid && n < 40) begin
            n++;
            step();
        end
        check_vec("trig90_ov", 32'(out_valid), 32'd1);
        check_vec("trig90_cos", ax, 32'h00000000, 4);
        check_vec("trig90_sin", ay, 32'h00010000, 4);
        idle_inputs();
        rd1 = 2; imm = 3; alu_src = 1; alu_ctrl = 4'd0; in_valid = 1;
        step();
        in_valid = 0;
        check_vec("b2b_res", alu_result, 32'd5);
        check_vec("b2b_ov", 32'(out_valid), 32'd1);

        // Flush in RUN cycle 5.
        start_trig(32'h0);
        repeat (4) step();
        flush = 1;
        step();
        flush = 0;
        check_vec("flush_busy", 32'(busy), 32'd0);
        check_vec("flush_ov", 32'(out_valid), 32'd0);
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) ov_seen++;
        end
        check_vec("flush_no_result", 32'(ov_seen), 32'd0);

        // Reset in cycle 8 of a trig op.
        start_trig(32'h0);
        repeat (7) step();
        rst = 1;
        step();
        rst = 0;
        check_vec("rst_mid_busy", 32'(busy), 32'd0);
        check_vec("rst_mid_ov", 32'(out_valid), 32'd0);
        check_vec("rst_mid_res", alu_result, 32'd0);
        check_vec("rst_mid_ax", ax, 32'd0);
        check_vec("rst_mid_ay", ay, 32'd0);
        check_vec("rst_mid_wd", wd, 32'd0);
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) ov_seen++;
        end
        check_vec("rst_mid_no_result", 32'(ov_seen), 32'd0);
`else
        // trig_op without the CORDIC: single-cycle MOV, ax/ay = r0/r1.
        idle_inputs();
        trig_op = 1; alu_ctrl = 4'd0; alu_src = 1; imm = 9; rd1 = 1; r0 = 3; r1 = 4; in_valid = 1;
        step();
        in_valid = 0; trig_op = 0;
        check_vec("notrig_busy", 32'(busy), 32'd0);
        check_vec("notrig_ov", 32'(out_valid), 32'd1);
        check_vec("notrig_ax", ax, 32'd3);
        check_vec("notrig_ay", ay, 32'd4);
        check_vec("notrig_mov", alu_result, 32'd9);

        // Reset clears registered results.
        alu_vec("pre_rst", 4'd3, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 4'b0000);
        rst = 1;
        step();
        rst = 0;
        check_vec("rst_clr_res", alu_result, 32'd0);
        check_vec("rst_clr_ov", 32'(out_valid), 32'd0);
        check_vec("rst_clr_ax", ax, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
